// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and helpers for the register-bus round-robin arbiter
package reg_arb_pkg;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Busy  = 2'd1,
        Drain = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_rr_select.sv
// rtl/reg_rr_select.sv - combinational first-valid search starting at rr_ptr with wrap-around
module reg_rr_select
    import reg_arb_pkg::*;
#(
    parameter int NumReq = 2,
    parameter int IdxW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] valid,
    input  logic [IdxW-1:0]   rr_ptr,
    output logic              found,
    output logic [IdxW-1:0]   index
);

    logic [IdxW-1:0] pos;

    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = '0;
        for (int i = 0; i < NumReq; i++) begin
            pos = IdxW'((int'(rr_ptr) + i) % NumReq);
            if (!found && valid[pos]) begin
                found = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/reg_arbiter.sv
// rtl/reg_arbiter.sv - round-robin register-bus arbiter with transaction lock and optional timeout/drain
module reg_arbiter
    import reg_arb_pkg::*;
#(
    parameter int  NumReq        = 2,
    parameter int  TimeoutCycles = 0,
    parameter type req_t         = reg_req_t,
    parameter type rsp_t         = reg_rsp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  req_t req_i [NumReq],
    output rsp_t rsp_o [NumReq],
    output req_t req_o,
    input  rsp_t rsp_i,
    output logic timeout_o
);

    localparam int IdxW = idx_width(NumReq);
    localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam bit TimeoutEn = (TimeoutCycles != 0);
    localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TimeoutCycles - 1) : '0;
    localparam logic [CntW-1:0] CntMax  = '1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] win_q, win_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    req_t            lat_q, lat_d;

    logic [NumReq-1:0] valid_vec;
    logic              sel_found;
    logic [IdxW-1:0]   sel_idx;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        return (i == LastIdx) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NumReq; i++) begin
            valid_vec[i] = req_i[i].valid;
        end
    end

    reg_rr_select #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_select (
        .valid  (valid_vec),
        .rr_ptr (rr_ptr_q),
        .found  (sel_found),
        .index  (sel_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= Idle;
            rr_ptr_q <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        req_o     = '0;
        timeout_o = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            rsp_o[i] = '0;
        end

        unique case (state_q)
            Idle: begin
                if (sel_found) begin
                    req_o          = req_i[sel_idx];
                    rsp_o[sel_idx] = rsp_i;
                    win_d          = sel_idx;
                    lat_d          = req_i[sel_idx];
                    cnt_d          = CntW'(1);
                    if (rsp_i.ready) begin
                        rr_ptr_d = next_idx(sel_idx);
                    end else begin
                        state_d = Busy;
                    end
                end
            end
            Busy: begin
                req_o        = req_i[win_q];
                rsp_o[win_q] = rsp_i;
                if (rsp_i.ready) begin
                    rr_ptr_d = next_idx(win_q);
                    state_d  = Idle;
                end else if (TimeoutEn && cnt_q == CntLast) begin
                    // Initiator is released with an error; the target keeps its request until it answers.
                    rsp_o[win_q]       = '0;
                    rsp_o[win_q].ready = 1'b1;
                    rsp_o[win_q].error = 1'b1;
                    timeout_o          = 1'b1;
                    rr_ptr_d           = next_idx(win_q);
                    state_d            = Drain;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            Drain: begin
                req_o       = lat_q;
                req_o.valid = 1'b1;
                if (rsp_i.ready) begin
                    state_d = Idle;
                end
            end
            default: begin
                state_d = Idle;
            end
        endcase

        if (!rst_ni) begin
            req_o     = '0;
            timeout_o = 1'b0;
            for (int i = 0; i < NumReq; i++) begin
                rsp_o[i] = '0;
            end
        end
    end

endmodule
